svc_pix_vga: RTL and testbench
==============================

SVC_PIX_VGA -- requirements
Module: svc_pix_vga

Interface
REQ-001 SHALL have parameter H_WIDTH, default 12: width of horizontal counters and x coordinates.
REQ-002 SHALL have parameter V_WIDTH, default 12: width of vertical counters and y coordinates.
REQ-003 SHALL have parameter COLOR_WIDTH, default 4: bits per colour channel.
REQ-004 SHALL have ports clk in 1 (clock) and rst_n in 1 (reset, synchronous, active-low).
REQ-005 SHALL have s_pix_valid in 1, s_pix_ready out 1: pixel stream handshake.
REQ-006 SHALL have s_pix_red, s_pix_grn, s_pix_blu, each in COLOR_WIDTH: pixel colour.
REQ-007 SHALL have s_pix_x in H_WIDTH and s_pix_y in V_WIDTH: pixel coordinates.
REQ-008 SHALL have h_visible, h_sync_start, h_sync_end, h_line_end, each in H_WIDTH: horizontal timing, with h_line_end the last count of a line.
REQ-009 SHALL have v_visible, v_sync_start, v_sync_end, v_frame_end, each in V_WIDTH: vertical timing.
REQ-010 SHALL have vga_hsync out 1, vga_vsync out 1, vga_red/vga_grn/vga_blu out COLOR_WIDTH each: display outputs.
REQ-011 SHALL have vga_error out 1: single-cycle pulse on underflow or coordinate mismatch.

Function
REQ-012 SHALL keep counters h (0..h_line_end) and v (0..v_frame_end); h increments every cycle and wraps to 0 after h_line_end; v increments on h wrap and wraps to 0 after v_frame_end.
REQ-013 SHALL define visible as h < h_visible and v < v_visible.
REQ-014 SHALL register vga_hsync = (h_sync_start <= h < h_sync_end) and vga_vsync = (v_sync_start <= v < v_sync_end), active high, one cycle after the counter value.
REQ-015 SHALL implement states SYNC and RUN.
REQ-016 In SYNC: colours black; s_pix_ready = 1 unless the presented pixel has x==0 and y==0, so all other pixels are dropped and pixel (0,0) is held.
REQ-017 SYNC -> RUN SHALL occur on the cycle where h==h_line_end, v==v_frame_end, s_pix_valid==1, s_pix_x==0 and s_pix_y==0; no pixel is consumed on that cycle.
REQ-018 In RUN: s_pix_ready = visible and colours are black outside the visible region.
REQ-019 In RUN, visible cycle with s_pix_valid and (s_pix_x,s_pix_y)==(h,v): pixel consumed; its colour is registered to vga_* with 1-cycle latency, aligned with hsync/vsync for the same counter value.
REQ-020 In RUN, visible cycle with !s_pix_valid (underflow): output black, vga_error=1 next cycle, next state SYNC.
REQ-021 In RUN, visible cycle with s_pix_valid and coordinate mismatch: the pixel is consumed (ready=1), output black, vga_error=1 next cycle, next state SYNC.
REQ-022 Coordinate comparisons SHALL be exact at full H_WIDTH/V_WIDTH with no truncation.
REQ-023 Timing inputs SHALL be treated as static; behaviour on mid-frame changes is unspecified apart from counters remaining in range (a counter > its end value wraps to 0 next increment).
REQ-024 SHALL hold the colour outputs at the last value when vga_* are not updated? No: every cycle SHALL drive vga_* freshly (pixel or black); no stale colour is output.

Reset
REQ-025 On rst_n==0: h=0, v=0, state SYNC, s_pix_ready=0, vga_hsync=0, vga_vsync=0, vga_red/grn/blu=0, vga_error=0.
REQ-026 Reset asserted mid-frame SHALL take effect on the next clock edge regardless of state; buffered upstream pixels are not consumed during reset.
REQ-027 After reset release, counters start at (0,0) in SYNC; first RUN entry is at the end of the first full frame.

Verification
REQ-028 Timing 4x2 visible, h_line_end=6, v_frame_end=3, source always valid with correct pixels starting (0,0) -> SYNC for one frame, then RUN; every visible cycle outputs the matching colour one cycle later; vga_error never asserts.
REQ-029 Source starts at (2,1) -> pixels dropped (ready=1) until (0,0) presented; (0,0) held with ready=0 until frame end; RUN begins at next frame.
REQ-030 In RUN, deassert s_pix_valid at (1,0) -> black output, vga_error pulse for exactly one cycle, state SYNC; resync at the following frame boundary.
REQ-031 In RUN, present (3,0) at counter (1,0) -> pixel consumed, black output, vga_error pulse, SYNC.
REQ-032 h_sync_start=5, h_sync_end=6, v_sync_start=2, v_sync_end=3 -> vga_hsync high one cycle per line, vga_vsync high for all of line 2, each delayed one cycle from the counter.
REQ-033 Assert rst_n=0 mid-RUN for one cycle -> all outputs 0, counters (0,0), state SYNC on next edge.

Source files
------------

// File: rtl/svc_pix_vga.sv
// Pixel-stream to VGA timing generator: raster counters, registered sync and colour
// outputs, and a SYNC/RUN aligner that locks the stream to the raster at frame end.
module svc_pix_vga #(
  parameter int H_WIDTH     = 12,
  parameter int V_WIDTH     = 12,
  parameter int COLOR_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_pix_valid,
  output logic                   s_pix_ready,
  input  logic [COLOR_WIDTH-1:0] s_pix_red,
  input  logic [COLOR_WIDTH-1:0] s_pix_grn,
  input  logic [COLOR_WIDTH-1:0] s_pix_blu,
  input  logic [H_WIDTH-1:0]     s_pix_x,
  input  logic [V_WIDTH-1:0]     s_pix_y,
  input  logic [H_WIDTH-1:0]     h_visible,
  input  logic [H_WIDTH-1:0]     h_sync_start,
  input  logic [H_WIDTH-1:0]     h_sync_end,
  input  logic [H_WIDTH-1:0]     h_line_end,
  input  logic [V_WIDTH-1:0]     v_visible,
  input  logic [V_WIDTH-1:0]     v_sync_start,
  input  logic [V_WIDTH-1:0]     v_sync_end,
  input  logic [V_WIDTH-1:0]     v_frame_end,
  output logic                   vga_hsync,
  output logic                   vga_vsync,
  output logic [COLOR_WIDTH-1:0] vga_red,
  output logic [COLOR_WIDTH-1:0] vga_grn,
  output logic [COLOR_WIDTH-1:0] vga_blu,
  output logic                   vga_error
);

  typedef enum logic {ST_SYNC, ST_RUN} state_t;

  state_t                 state_q, state_d;
  logic [H_WIDTH-1:0]     h_q, h_d;
  logic [V_WIDTH-1:0]     v_q, v_d;
  logic                   hsync_q, hsync_d;
  logic                   vsync_q, vsync_d;
  logic [COLOR_WIDTH-1:0] red_q, red_d;
  logic [COLOR_WIDTH-1:0] grn_q, grn_d;
  logic [COLOR_WIDTH-1:0] blu_q, blu_d;
  logic                   error_q, error_d;
  logic                   ready_c;

  logic h_wrap, v_wrap, visible, coord_match, pix_is_origin, at_frame_end;

  // Wrap on >= so a counter stranded above a shrunken end value recovers.
  assign h_wrap        = (h_q >= h_line_end);
  assign v_wrap        = (v_q >= v_frame_end);
  assign visible       = (h_q < h_visible) && (v_q < v_visible);
  assign coord_match   = (s_pix_x == h_q) && (s_pix_y == v_q);
  assign pix_is_origin = (s_pix_x == '0) && (s_pix_y == '0);
  assign at_frame_end  = (h_q == h_line_end) && (v_q == v_frame_end);

  always_comb begin
    h_d = h_wrap ? '0 : h_q + H_WIDTH'(1);
    v_d = v_q;
    if (h_wrap) begin
      v_d = v_wrap ? '0 : v_q + V_WIDTH'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    red_d   = '0;
    grn_d   = '0;
    blu_d   = '0;
    error_d = 1'b0;
    hsync_d = (h_q >= h_sync_start) && (h_q < h_sync_end);
    vsync_d = (v_q >= v_sync_start) && (v_q < v_sync_end);
    case (state_q)
      ST_SYNC: begin
        // Drain everything except the frame origin, which is parked until frame end.
        ready_c = !pix_is_origin;
        if (at_frame_end && s_pix_valid && pix_is_origin) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        ready_c = visible;
        if (visible) begin
          if (s_pix_valid && coord_match) begin
            red_d = s_pix_red;
            grn_d = s_pix_grn;
            blu_d = s_pix_blu;
          end else begin
            error_d = 1'b1;
            state_d = ST_SYNC;
          end
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  assign s_pix_ready = rst_n & ready_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_SYNC;
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      red_q   <= '0;
      grn_q   <= '0;
      blu_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      red_q   <= red_d;
      grn_q   <= grn_d;
      blu_q   <= blu_d;
      error_q <= error_d;
    end
  end

  assign vga_hsync = hsync_q;
  assign vga_vsync = vsync_q;
  assign vga_red   = red_q;
  assign vga_grn   = grn_q;
  assign vga_blu   = blu_q;
  assign vga_error = error_q;

endmodule

// File: tb/tb_svc_pix_vga.sv
// Scoreboard bench for svc_pix_vga: the driver queues expected ready and output words,
// a monitor pops and compares them on the falling edge.
module tb_svc_pix_vga;
  localparam int HW = 12;
  localparam int VW = 12;
  localparam int CW = 4;
  localparam int H_VIS = 4, H_SS = 5, H_SE = 6, H_END = 6;
  localparam int V_VIS = 2, V_SS = 2, V_SE = 3, V_END = 3;
  localparam int FRAME = (H_END + 1) * (V_END + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_pix_valid;
  logic          s_pix_ready;
  logic [CW-1:0] s_pix_red, s_pix_grn, s_pix_blu;
  logic [HW-1:0] s_pix_x;
  logic [VW-1:0] s_pix_y;
  logic [HW-1:0] h_visible, h_sync_start, h_sync_end, h_line_end;
  logic [VW-1:0] v_visible, v_sync_start, v_sync_end, v_frame_end;
  logic          vga_hsync, vga_vsync, vga_error;
  logic [CW-1:0] vga_red, vga_grn, vga_blu;

  always #5 clk = ~clk;

  svc_pix_vga #(.H_WIDTH(HW), .V_WIDTH(VW), .COLOR_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_pix_valid(s_pix_valid), .s_pix_ready(s_pix_ready),
    .s_pix_red(s_pix_red), .s_pix_grn(s_pix_grn), .s_pix_blu(s_pix_blu),
    .s_pix_x(s_pix_x), .s_pix_y(s_pix_y),
    .h_visible(h_visible), .h_sync_start(h_sync_start),
    .h_sync_end(h_sync_end), .h_line_end(h_line_end),
    .v_visible(v_visible), .v_sync_start(v_sync_start),
    .v_sync_end(v_sync_end), .v_frame_end(v_frame_end),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_red(vga_red), .vga_grn(vga_grn), .vga_blu(vga_blu),
    .vga_error(vga_error)
  );

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
    logic          err;
  } exp_t;

  exp_t q_out[$];
  bit   q_rdy[$];

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int hs_seen = 0;
  int err_base, hs_base;

  int ref_h, ref_v;
  bit ref_run;
  int src_x, src_y;
  bit src_valid;
  bit arm_underflow, arm_mismatch;
  int cyc = 0;

  // Monitor: ready is checked within the cycle, registered outputs one edge later.
  initial begin
    bit   r;
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (s_pix_valid && s_pix_ready && rst_n) hs_seen++;
      if (vga_error === 1'b1) err_seen++;
      if (q_rdy.size() > 0) begin
        r = q_rdy.pop_front();
        checks++;
        if (s_pix_ready !== r) begin
          errors++;
          $display("FAIL ready t=%0t got=%b want=%b", $time, s_pix_ready, r);
        end
      end
      if (q_out.size() > 0) begin
        e = q_out.pop_front();
        a = {vga_hsync, vga_vsync, vga_red, vga_grn, vga_blu, vga_error};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL vga_out t=%0t got hs=%b vs=%b rgb=%h/%h/%h err=%b want hs=%b vs=%b rgb=%h/%h/%h err=%b",
                   $time, a.hs, a.vs, a.r, a.g, a.b, a.err, e.hs, e.vs, e.r, e.g, e.b, e.err);
        end
      end
    end
  end

  // One clock of stimulus; called just after a rising edge.
  task automatic cycle(input bit rst);
    exp_t e;
    bit   rdy, vis, next_run, v_in;
    int   px, py;
    px = src_x;
    py = src_y;
    v_in = src_valid;
    if (!rst && ref_run && ref_h == 1 && ref_v == 0) begin
      if (arm_underflow) begin
        v_in = 1'b0;
        arm_underflow = 1'b0;
      end else if (arm_mismatch) begin
        px = 3;
        py = 0;
        arm_mismatch = 1'b0;
      end
    end
    rst_n       = !rst;
    s_pix_valid = v_in;
    s_pix_x     = HW'(px);
    s_pix_y     = VW'(py);
    s_pix_red   = CW'(px);
    s_pix_grn   = CW'(py);
    s_pix_blu   = CW'(px + py + 1);
    e = '0;
    rdy = 1'b0;
    if (rst) begin
      ref_h = 0;
      ref_v = 0;
      ref_run = 1'b0;
    end else begin
      e.hs = (ref_h >= H_SS) && (ref_h < H_SE);
      e.vs = (ref_v >= V_SS) && (ref_v < V_SE);
      vis = (ref_h < H_VIS) && (ref_v < V_VIS);
      next_run = ref_run;
      if (!ref_run) begin
        rdy = !(px == 0 && py == 0);
        if (ref_h == H_END && ref_v == V_END && v_in && px == 0 && py == 0) next_run = 1'b1;
      end else begin
        rdy = vis;
        if (vis) begin
          if (v_in && px == ref_h && py == ref_v) begin
            e.r = CW'(px);
            e.g = CW'(py);
            e.b = CW'(px + py + 1);
          end else begin
            e.err = 1'b1;
            next_run = 1'b0;
          end
        end
      end
      if (v_in && rdy) begin
        src_x = px + 1;
        src_y = py;
        if (src_x == H_VIS) begin
          src_x = 0;
          src_y = py + 1;
          if (src_y == V_VIS) src_y = 0;
        end
      end
      ref_run = next_run;
      if (ref_h == H_END) begin
        ref_h = 0;
        ref_v = (ref_v == V_END) ? 0 : ref_v + 1;
      end else begin
        ref_h = ref_h + 1;
      end
    end
    q_rdy.push_back(rdy);
    @(posedge clk);
    q_out.push_back(e);
    cyc++;
    #1;
  endtask

  task automatic mark();
    err_base = err_seen;
    hs_base  = hs_seen;
  endtask

  task automatic scen_check(input string name, input int want_err, input int want_hs);
    checks++;
    if (err_seen - err_base != want_err) begin
      errors++;
      $display("FAIL %s_error_pulses got=%0d want=%0d", name, err_seen - err_base, want_err);
    end
    checks++;
    if (hs_seen - hs_base != want_hs) begin
      errors++;
      $display("FAIL %s_handshakes got=%0d want=%0d", name, hs_seen - hs_base, want_hs);
    end
    $display("scenario %s: error pulses %0d, handshakes %0d", name, err_seen - err_base, hs_seen - hs_base);
  endtask

  initial begin
    rst_n = 1'b0;
    s_pix_valid = 1'b0;
    s_pix_x = '0; s_pix_y = '0;
    s_pix_red = '0; s_pix_grn = '0; s_pix_blu = '0;
    h_visible = HW'(H_VIS); h_sync_start = HW'(H_SS); h_sync_end = HW'(H_SE); h_line_end = HW'(H_END);
    v_visible = VW'(V_VIS); v_sync_start = VW'(V_SS); v_sync_end = VW'(V_SE); v_frame_end = VW'(V_END);
    arm_underflow = 1'b0;
    arm_mismatch = 1'b0;
    ref_h = 0; ref_v = 0; ref_run = 1'b0;
    @(posedge clk);
    #1;

    // Aligned source from (0,0): one SYNC frame, then two RUN frames of 8 pixels.
    src_x = 0; src_y = 0; src_valid = 1'b1;
    repeat (2) cycle(1'b1);
    mark();
    repeat (3 * FRAME) cycle(1'b0);
    scen_check("aligned_start", 0, 16);

    // Misaligned source from (2,1): two drops, origin held, then two RUN frames.
    src_x = 2; src_y = 1;
    repeat (2) cycle(1'b1);
    mark();
    repeat (3 * FRAME) cycle(1'b0);
    scen_check("misaligned_start", 0, 18);

    // Underflow at (1,0): one consumed, seven dropped, resync, 16 consumed.
    arm_underflow = 1'b1;
    mark();
    repeat (3 * FRAME) cycle(1'b0);
    scen_check("underflow", 1, 24);

    // Pixel (3,0) at counter (1,0): consumed as an error, four dropped, resync.
    arm_mismatch = 1'b1;
    mark();
    repeat (3 * FRAME) cycle(1'b0);
    scen_check("mismatch", 1, 22);

    // One-cycle reset in the middle of a RUN frame.
    mark();
    repeat (10) cycle(1'b0);
    cycle(1'b1);
    repeat (3 * FRAME) cycle(1'b0);
    scen_check("mid_reset", 0, 24);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q_out.size() != 0 || q_rdy.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d/%0d want=0/0", q_out.size(), q_rdy.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
